// File: rtl/ring_sequence_checker.sv
// ring_sequence_checker: decodes a one-hot ring bus, locks onto its rotation and counts sequence breaks
module ring_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int IDX_W      = 2,
  parameter bit SHIFT_LEFT = 1'b1,
  parameter int LOCK_LEN   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [7:0]       err_count
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic             prev_ok_q;
  logic [3:0]       run_q;
  logic [3:0]       run_d;
  logic [IDX_W-1:0] idx_q;
  logic             idx_valid_q;
  logic             err_q;
  logic             wrap_q;
  logic [7:0]       err_count_q;
  logic [7:0]       err_count_d;
  logic [WIDTH-1:0] rot;
  logic             onehot;
  logic             legal;
  logic [IDX_W-1:0] pos;
  assign rot = SHIFT_LEFT ? {prev_q[WIDTH-2:0], prev_q[WIDTH-1]} : {prev_q[0], prev_q[WIDTH-1:1]};
  assign onehot = (ring_in != '0) && ((ring_in & (ring_in - 1'b1)) == '0);
  assign legal = prev_ok_q && (ring_in == rot);
  assign run_d = run_q + 4'd1;
  assign err_count_d = (err_count_q == 8'hff) ? err_count_q : err_count_q + 8'd1;
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++)
      if (ring_in[i]) pos = IDX_W'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      run_q       <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      idx_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      if (en) begin
        idx_valid_q <= onehot;
        if (onehot) idx_q <= pos;
        // every sample seeds the next comparison, including a break value
        prev_q    <= ring_in;
        prev_ok_q <= onehot;
        if (state_q == HUNT) begin
          if (legal && run_d == 4'(LOCK_LEN)) begin
            state_q <= LOCKED;
            run_q   <= '0;
          end else begin
            run_q <= legal ? run_d : 4'd0;
          end
        end else if (legal) begin
          wrap_q <= ring_in[0];
        end else begin
          err_q       <= 1'b1;
          err_count_q <= err_count_d;
          state_q     <= HUNT;
          run_q       <= '0;
        end
      end
    end
  end
  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign locked     = (state_q == LOCKED);
  assign err_pulse  = err_q;
  assign wrap_pulse = wrap_q;
  assign err_count  = err_count_q;
endmodule

// File: tb/tb_ring_sequence_checker.sv
// tb_ring_sequence_checker: directed self-checking bench for ring_sequence_checker
module tb_ring_sequence_checker;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] ring_in;
  logic [1:0] idx;
  logic       idx_valid;
  logic       locked;
  logic       err_pulse;
  logic       wrap_pulse;
  logic [7:0] err_count;
  int         n_chk = 0;
  int         n_fail = 0;
  ring_sequence_checker #(.WIDTH(4), .IDX_W(2), .SHIFT_LEFT(1'b1), .LOCK_LEN(2)) dut (
    .clk(clk), .rst(rst), .en(en), .ring_in(ring_in), .idx(idx), .idx_valid(idx_valid),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic all(input string tag, input logic iv, input logic [1:0] ix, input logic lk,
                     input logic er, input logic wr, input logic [7:0] ec);
    chk({tag, ".idx_valid"}, 32'(idx_valid), 32'(iv));
    chk({tag, ".idx"}, 32'(idx), 32'(ix));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(er));
    chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(wr));
    chk({tag, ".err_count"}, 32'(err_count), 32'(ec));
  endtask
  task automatic step(input logic e, input logic [3:0] r);
    @(negedge clk);
    en = e;
    ring_in = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b1;
    ring_in = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 4'b0001); all("s1a", 1, 0, 0, 0, 0, 0);
    step(1, 4'b0010); all("s1b", 1, 1, 0, 0, 0, 0);
    step(1, 4'b0100); all("s1c", 1, 2, 1, 0, 0, 0);
    step(1, 4'b1000); all("s2a", 1, 3, 1, 0, 0, 0);
    step(1, 4'b0001); all("s2wrap", 1, 0, 1, 0, 1, 0);
    step(1, 4'b0110); all("s3brk", 0, 0, 0, 1, 0, 1);
    step(1, 4'b0001); all("s3a", 1, 0, 0, 0, 0, 1);
    step(1, 4'b0010); all("s3b", 1, 1, 0, 0, 0, 1);
    step(1, 4'b0100); all("s3relock", 1, 2, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'($urandom_range(0, 15)));
      all("s4hold", 0, 2, 1, 0, 0, 1);
    end
    step(1, 4'b1000); all("s4resume", 1, 3, 1, 0, 0, 1);
    step(1, 4'b1000); all("repeat", 1, 3, 0, 1, 0, 2);
    step(1, 4'b0001); all("seed1", 1, 0, 0, 0, 0, 2);
    step(1, 4'b0010); all("seed2", 1, 1, 1, 0, 0, 2);
    step(1, 4'b0000); all("zero", 0, 1, 0, 1, 0, 3);
    step(1, 4'b0001);
    step(1, 4'b0010);
    step(1, 4'b0100); all("pre_rst", 1, 2, 1, 0, 0, 3);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    ring_in = 4'b1000;
    @(posedge clk);
    #1;
    all("s6rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1, 4'b0001);
      step(1, 4'b0010);
      step(1, 4'b0100);
      step(1, 4'b0000);
      if (i == 253) chk("sat254", 32'(err_count), 32'd254);
      if (i == 254) chk("sat255", 32'(err_count), 32'd255);
    end
    all("s5sat", 0, 2, 0, 1, 0, 8'd255);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
